// File: rtl/sim_input_player_if.sv
// ioctl download port of the sim-top input player: the host drives the byte stream,
// and the player returns ioctl_wait as backpressure.
interface sim_input_player_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait
  );
endinterface

// File: rtl/sim_input_player.sv
// Frame-coherent input source for the sim top: latches live joystick/analog at vblank,
// or replays a downloaded 8-byte-record script through a backpressured FIFO.
module sim_input_player #(
  parameter int         NUM_JOY      = 6,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] SCRIPT_INDEX = 8'd2
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    vblank,
  input  logic [NUM_JOY*32-1:0]   joystick_in,
  input  logic [NUM_JOY*16-1:0]   analog_in,
  sim_input_player_if.slave       ioctl,
  output logic [NUM_JOY*32-1:0]   joystick_out,
  output logic [NUM_JOY*16-1:0]   analog_out,
  output logic                    playing,
  output logic                    bad_record
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] NJ     = 8'(NUM_JOY);
  localparam logic [7:0] CH_END = 8'hFF;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] APPLY      = 2'd2;
  localparam logic [1:0] HOLD       = 2'd3;

  logic [1:0]    state;
  logic          vb_q, dl_q, wait_full;
  logic [7:0]    hold_cnt;
  logic [55:0]   asm_q;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_idx;
  logic [CW-1:0] count, next_count;

  logic          frame_tick, idx_match, start, accept, push, pop;
  logic [2:0]    lane;
  logic [63:0]   head;
  logic [7:0]    head_ch, head_hold;
  logic [31:0]   head_btn;
  logic [15:0]   head_ana;
  logic [55:0]   asm_base;
  logic          unused_addr;

  assign frame_tick = vblank & ~vb_q;
  assign idx_match  = (ioctl.ioctl_index == SCRIPT_INDEX);
  assign start      = ioctl.ioctl_download & ~dl_q & idx_match;
  assign accept     = ioctl.ioctl_wr & ~wait_full & ioctl.ioctl_download & idx_match;
  assign lane       = ioctl.ioctl_addr[2:0];
  assign push       = accept & (lane == 3'd7);
  assign pop        = (state == APPLY) & (count != '0) & ~start;
  assign unused_addr = ^ioctl.ioctl_addr[24:3];

  assign ioctl.ioctl_wait = wait_full;

  // A byte arriving in the start cycle lands in a freshly cleared assembler/FIFO.
  assign asm_base = start ? '0 : asm_q;
  assign wr_idx   = start ? '0 : wr_ptr;

  assign head      = mem[rd_ptr];
  assign head_ch   = head[7:0];
  assign head_btn  = head[39:8];
  assign head_ana  = head[55:40];
  assign head_hold = head[63:56];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_count = count;
    if (start) begin
      next_count = push ? CW'(1) : '0;
    end else begin
      case ({push, pop})
        2'b10:   next_count = count + CW'(1);
        2'b01:   next_count = count - CW'(1);
        default: next_count = count;
      endcase
    end
  end

  // NOTE: record storage has no reset; count/pointers alone define what is valid.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_idx] <= {ioctl.ioctl_dout, asm_base};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      vb_q         <= 1'b0;
      dl_q         <= 1'b0;
      wait_full    <= 1'b0;
      hold_cnt     <= '0;
      asm_q        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      joystick_out <= '0;
      analog_out   <= '0;
      playing      <= 1'b0;
      bad_record   <= 1'b0;
    end else begin
      vb_q  <= vblank;
      dl_q  <= ioctl.ioctl_download;
      count <= next_count;
      // Registered full flag looks at next_count so a push can never land on a full FIFO.
      wait_full <= (next_count == CW'(FIFO_DEPTH));

      if (start) asm_q <= '0;
      for (int l = 0; l < 7; l++) begin
        if (accept && lane == 3'(l)) asm_q[l*8 +: 8] <= ioctl.ioctl_dout;
      end

      if (start) begin
        rd_ptr <= '0;
        wr_ptr <= push ? AW'(1) : '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end

      if (start) begin
        state    <= WAIT_FRAME;
        playing  <= 1'b1;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_tick) begin
              joystick_out <= joystick_in;
              analog_out   <= analog_in;
            end
          end
          WAIT_FRAME: begin
            if (frame_tick) state <= APPLY;
          end
          APPLY: begin
            if (count == '0) begin
              state <= WAIT_FRAME;
            end else if (head_ch == CH_END) begin
              playing <= 1'b0;
              state   <= IDLE;
            end else if (head_ch >= NJ) begin
              bad_record <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_JOY; i++) begin
                if (head_ch == 8'(i)) begin
                  joystick_out[i*32 +: 32] <= head_btn;
                  analog_out[i*16 +: 16]   <= head_ana;
                end
              end
              if (head_hold != '0) begin
                hold_cnt <= head_hold;
                state    <= HOLD;
              end
            end
          end
          HOLD: begin
            if (frame_tick) begin
              hold_cnt <= hold_cnt - 8'd1;
              if (hold_cnt == 8'd1) state <= APPLY;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
